fc_neuron_seq: RTL and testbench

- Sequential, parametrised fully-connected neuron.
- Streams N_IN input/weight pairs, LANES pairs per beat, over a valid/ready handshake into a signed accumulator pre-loaded with the bias.
- Returns one OUT_WIDTH dot-product result, with optional ReLU, over a second valid/ready handshake.
- Successor to the fixed 84-input combinational FC neuron: one instance serves any FC layer size at LANES multipliers instead of N_IN.

---
 rtl/fc_neuron_seq.sv | 121 ++++++++++++
 tb/tb_fc_neuron_seq.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_neuron_seq.sv
// Sequential fully-connected neuron: streams N_IN input/weight pairs,
// LANES per beat, into a bias-preloaded signed accumulator and returns
// one OUT_WIDTH dot product (optionally ReLU-clamped) over valid/ready.
module fc_neuron_seq #(
    parameter int BIT_WIDTH = 32,
    parameter int OUT_WIDTH = 64,
    parameter int N_IN      = 84,
    parameter int LANES     = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [BIT_WIDTH-1:0]           bias,
    input  logic                           relu_en,
    output logic                           busy,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [BIT_WIDTH*LANES-1:0]     in_data,
    input  logic [BIT_WIDTH*LANES-1:0]     in_weights,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OUT_WIDTH-1:0]           out_data
);

    localparam int BEATS = N_IN / LANES;
    localparam int CW    = $clog2(BEATS) + 1;
    localparam int PW    = 2 * BIT_WIDTH;

    if (N_IN % LANES != 0) begin : g_lane_check
        $error("fc_neuron_seq: N_IN must be a multiple of LANES");
    end
    if (OUT_WIDTH < 2 * BIT_WIDTH) begin : g_width_check
        $error("fc_neuron_seq: OUT_WIDTH must be at least 2*BIT_WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic signed [OUT_WIDTH-1:0]  acc_q, acc_d;
    logic        [CW-1:0]         cnt_q, cnt_d;
    logic                         relu_q, relu_d;
    logic        [OUT_WIDTH-1:0]  out_q, out_d;

    logic signed [OUT_WIDTH-1:0]  beat_sum;
    logic signed [OUT_WIDTH-1:0]  final_sum;

    // Sum of the LANES full-width signed products of the current beat (wraps).
    always_comb begin
        logic signed [PW-1:0] prod;
        beat_sum = '0;
        prod     = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            prod = PW'($signed(in_data[BIT_WIDTH*k +: BIT_WIDTH]))
                 * PW'($signed(in_weights[BIT_WIDTH*k +: BIT_WIDTH]));
            beat_sum = beat_sum + OUT_WIDTH'(prod);
        end
        final_sum = acc_q + beat_sum;
    end

    // Next-state and datapath update for the IDLE/ACC/DONE sequence.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        relu_d  = relu_q;
        out_d   = out_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = OUT_WIDTH'($signed(bias));
                    relu_d  = relu_en;
                    cnt_d   = '0;
                    state_d = ACC;
                end
            end
            ACC: begin
                if (in_valid) begin
                    acc_d = final_sum;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(BEATS - 1)) begin
                        out_d   = (relu_q && final_sum[OUT_WIDTH-1]) ? '0 : final_sum;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            relu_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            relu_q  <= relu_d;
            out_q   <= out_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_q;

endmodule

// File: tb/tb_fc_neuron_seq.sv
// Bench for fc_neuron_seq (N_IN=8, LANES=4, 32-bit operands, 64-bit result).
module tb_fc_neuron_seq;

    localparam int BW    = 32;
    localparam int OW    = 64;
    localparam int NIN   = 8;
    localparam int LN    = 4;
    localparam int BEATS = NIN / LN;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [BW-1:0]     bias;
    logic              relu_en;
    logic              busy;
    logic              in_valid;
    logic              in_ready;
    logic [BW*LN-1:0]  in_data;
    logic [BW*LN-1:0]  in_weights;
    logic              out_valid;
    logic              out_ready;
    logic [OW-1:0]     out_data;

    fc_neuron_seq #(
        .BIT_WIDTH (BW),
        .OUT_WIDTH (OW),
        .N_IN      (NIN),
        .LANES     (LN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bias       (bias),
        .relu_en    (relu_en),
        .busy       (busy),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_weights (in_weights),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    int dvec [NIN];
    int wvec [NIN];

    logic          obs_ready_after_start;
    logic          obs_valid_after_last;
    logic          obs_ready_after_last;
    logic          obs_valid_after_hs;
    logic          obs_busy_after_hs;
    logic [OW-1:0] obs_data;
    bit            obs_stable;
    bit            obs_timeout;

    // Reference: plain 64-bit signed arithmetic of bias + sum(d*w), wrapping.
    function automatic longint model(input int b, input bit r);
        longint s;
        s = longint'(b);
        for (int i = 0; i < NIN; i++) s = s + longint'(dvec[i]) * longint'(wvec[i]);
        if (r && s < 0) s = 0;
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one complete neuron; records observations for the caller to check.
    task automatic drive(input int b, input bit r, input logic [31:0] vpat,
                         input int stall, input bit junk);
        int            nb;
        int            cyc;
        bit            acc;
        logic [OW-1:0] first;
        obs_timeout = 0;
        obs_stable  = 1;
        start   = 1'b1;
        bias    = b;
        relu_en = r;
        step();
        start   = 1'b0;
        bias    = '0;
        relu_en = 1'b0;
        obs_ready_after_start = in_ready;
        nb  = 0;
        cyc = 0;
        while (nb < BEATS && !obs_timeout) begin
            in_valid = (cyc < 32) ? vpat[cyc] : 1'b1;
            for (int k = 0; k < LN; k++) begin
                in_data[BW*k +: BW]    = in_valid ? dvec[nb*LN+k] : $urandom;
                in_weights[BW*k +: BW] = in_valid ? wvec[nb*LN+k] : $urandom;
            end
            start = junk;
            bias  = 100;
            acc   = in_valid && in_ready;
            step();
            if (acc) nb++;
            cyc++;
            if (cyc > 200) obs_timeout = 1;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        bias     = '0;
        obs_valid_after_last = out_valid;
        obs_ready_after_last = in_ready;
        first = out_data;
        for (int i = 0; i < stall; i++) begin
            if (out_valid !== 1'b1 || out_data !== first) obs_stable = 0;
            step();
        end
        if (out_valid !== 1'b1 || out_data !== first) obs_stable = 0;
        obs_data  = out_data;
        out_ready = 1'b1;
        start     = junk;
        bias      = 100;
        step();
        out_ready = 1'b0;
        start     = 1'b0;
        bias      = '0;
        obs_valid_after_hs = out_valid;
        obs_busy_after_hs  = busy;
    endtask

    task automatic fill_const(input int d, input int w);
        for (int i = 0; i < NIN; i++) begin
            dvec[i] = d;
            wvec[i] = w;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, in_ready, out_valid} !== 3'b000 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b in_ready=%b out_valid=%b out_data=%h, required all 0",
                     busy, in_ready, out_valid, out_data);
        end
    endtask

    task automatic test_basic();
        fill_const(1, 2);
        drive(3, 1'b0, 32'hFFFF_FFFF, 0, 1'b0);
        checks++;
        if (obs_timeout || obs_ready_after_start !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready_latency: in_ready=%b timeout=%0d, required 1/0",
                     obs_ready_after_start, obs_timeout);
        end
        checks++;
        if (obs_valid_after_last !== 1'b1 || obs_ready_after_last !== 1'b0) begin
            errors++;
            $display("FAIL basic_out_latency: out_valid=%b in_ready=%b, required 1/0",
                     obs_valid_after_last, obs_ready_after_last);
        end
        checks++;
        if (obs_data !== 64'd19) begin
            errors++;
            $display("FAIL basic_data: got %0d, required 19", $signed(obs_data));
        end
        checks++;
        if (obs_valid_after_hs !== 1'b0 || obs_busy_after_hs !== 1'b0) begin
            errors++;
            $display("FAIL basic_release: out_valid=%b busy=%b, required 0/0",
                     obs_valid_after_hs, obs_busy_after_hs);
        end
    endtask

    task automatic test_negative_relu();
        for (int i = 0; i < NIN; i++) begin
            dvec[i] = i + 1;
            wvec[i] = -1;
        end
        drive(10, 1'b0, 32'hFFFF_FFFF, 0, 1'b0);
        checks++;
        if (obs_data !== 64'hFFFF_FFFF_FFFF_FFE6) begin
            errors++;
            $display("FAIL negative_data: got %h, required ffffffffffffffe6", obs_data);
        end
        drive(10, 1'b1, 32'hFFFF_FFFF, 0, 1'b0);
        checks++;
        if (obs_data !== 64'd0) begin
            errors++;
            $display("FAIL relu_clamp: got %h, required 0", obs_data);
        end
    endtask

    task automatic test_bubbles_stall();
        fill_const(1, 2);
        drive(3, 1'b0, 32'hFFFF_FFF9, 5, 1'b0);
        checks++;
        if (obs_data !== 64'd19 || obs_timeout) begin
            errors++;
            $display("FAIL bubble_data: got %0d timeout=%0d, required 19",
                     $signed(obs_data), obs_timeout);
        end
        checks++;
        if (!obs_stable) begin
            errors++;
            $display("FAIL stall_hold: out_valid/out_data changed during stall, required stable");
        end
        checks++;
        if (obs_valid_after_hs !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: out_valid=%b, required 0", obs_valid_after_hs);
        end
    endtask

    task automatic test_mid_reset();
        fill_const(7, 5);
        start   = 1'b1;
        bias    = 1000;
        relu_en = 1'b0;
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < LN; k++) begin
            in_data[BW*k +: BW]    = dvec[k];
            in_weights[BW*k +: BW] = wvec[k];
        end
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, in_ready, out_valid} !== 3'b000 || out_data !== '0) begin
            errors++;
            $display("FAIL async_reset: busy=%b in_ready=%b out_valid=%b out_data=%h, required all 0",
                     busy, in_ready, out_valid, out_data);
        end
        step();
        rst_n = 1'b1;
        step();
        fill_const(1, 2);
        drive(3, 1'b0, 32'hFFFF_FFFF, 0, 1'b0);
        checks++;
        if (obs_data !== 64'd19) begin
            errors++;
            $display("FAIL reset_residue: got %0d, required 19", $signed(obs_data));
        end
    endtask

    task automatic test_start_ignored();
        fill_const(1, 2);
        drive(3, 1'b0, 32'hFFFF_FFFF, 2, 1'b1);
        checks++;
        if (obs_data !== 64'd19) begin
            errors++;
            $display("FAIL start_ignored_data: got %0d, required 19", $signed(obs_data));
        end
        checks++;
        if (obs_busy_after_hs !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored_busy: busy=%b, required 0", obs_busy_after_hs);
        end
        fill_const(3, 4);
        drive(-5, 1'b0, 32'hFFFF_FFFF, 0, 1'b0);
        checks++;
        if (obs_data !== 64'd91) begin
            errors++;
            $display("FAIL start_after_ignore: got %0d, required 91", $signed(obs_data));
        end
    endtask

    task automatic test_wrap();
        fill_const(int'(32'h8000_0000), int'(32'h8000_0000));
        drive(0, 1'b0, 32'hFFFF_FFFF, 0, 1'b0);
        checks++;
        if (obs_data !== 64'd0) begin
            errors++;
            $display("FAIL wrap_data: got %h, required 0", obs_data);
        end
        for (int i = 0; i < NIN; i++) begin
            dvec[i] = int'(32'h8000_0000);
            wvec[i] = (i == 0) ? 32'sh7FFF_FFFF : 0;
        end
        drive(0, 1'b0, 32'hFFFF_FFFF, 0, 1'b0);
        checks++;
        if (obs_data !== 64'hC000_0000_8000_0000) begin
            errors++;
            $display("FAIL sign_product: got %h, required c000000080000000", obs_data);
        end
    endtask

    task automatic test_random();
        int            b;
        bit            r;
        longint        exp_v;
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < NIN; i++) begin
                dvec[i] = (t % 2 == 0) ? $urandom : $urandom_range(0, 2000) - 1000;
                wvec[i] = (t % 2 == 0) ? $urandom : $urandom_range(0, 2000) - 1000;
            end
            b     = $urandom;
            r     = $urandom_range(0, 1);
            exp_v = model(b, r);
            drive(b, r, $urandom, $urandom_range(0, 3), 1'b0);
            checks++;
            if (obs_data !== exp_v || obs_timeout || !obs_stable) begin
                errors++;
                $display("FAIL random_%0d: got %h stable=%0d timeout=%0d, required %h",
                         t, obs_data, obs_stable, obs_timeout, exp_v);
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        bias       = '0;
        relu_en    = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_weights = '0;
        out_ready  = 1'b0;
        step();
        step();
        test_reset();
        rst_n = 1'b1;
        step();
        test_basic();
        test_negative_relu();
        test_bubbles_stall();
        test_mid_reset();
        test_start_ignored();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
